// File: rtl/wb_port_sequencer.sv
// Arbitrates the single register-file write port between MEM/WB writeback and a
// long-latency unit, splitting fp double results into two consecutive 32-bit writes.
module wb_port_sequencer #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_regwrite,
    input  logic        wb_mem_read,
    input  logic [1:0]  wb_float,
    input  logic [4:0]  wb_dest,
    input  logic [31:0] wb_mem_data,
    input  logic [63:0] wb_alu_res,
    input  logic        lu_req,
    input  logic        lu_fp,
    input  logic [4:0]  lu_dest,
    input  logic [31:0] lu_data,
    output logic        lu_ack,
    output logic        stall_o,
    output logic        rf_we,
    output logic        rf_fp,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_wdata
);

    typedef enum logic {IDLE, HI} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   wait_q, wait_d;
    logic [31:0]        hi_buf_q, hi_buf_d;
    logic [4:0]         hi_addr_q, hi_addr_d;
    logic               we_q, we_d;
    logic               fp_q, fp_d;
    logic [4:0]         addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               ack_c, stall_c;
    logic               int_rf, pv, is_dbl, starve;
    logic [31:0]        pipe_wdata;

    always_comb begin
        int_rf     = (wb_float == 2'b00) || (wb_float == 2'b11);
        pv         = wb_regwrite && !(int_rf && (wb_dest == 5'd0));
        is_dbl     = (wb_float == 2'b10) && !wb_mem_read;
        pipe_wdata = wb_mem_read ? wb_mem_data : wb_alu_res[31:0];
        starve     = lu_req && (wait_q == CNT_W'(STARVE_LIMIT));

        state_d   = state_q;
        hi_buf_d  = hi_buf_q;
        hi_addr_d = hi_addr_q;
        we_d      = 1'b0;
        fp_d      = fp_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ack_c     = 1'b0;
        stall_c   = 1'b0;

        case (state_q)
            IDLE: begin
                // A starved long-latency request beats the pipe, which must then hold.
                if (starve) begin
                    ack_c   = 1'b1;
                    we_d    = 1'b1;
                    fp_d    = lu_fp;
                    addr_d  = lu_dest;
                    wdata_d = lu_data;
                    stall_c = pv;
                end else if (pv) begin
                    we_d    = 1'b1;
                    fp_d    = !int_rf;
                    addr_d  = wb_dest;
                    wdata_d = pipe_wdata;
                    if (is_dbl) begin
                        hi_buf_d  = wb_alu_res[63:32];
                        hi_addr_d = wb_dest + 5'd1;
                        stall_c   = 1'b1;
                        state_d   = HI;
                    end
                end else if (lu_req) begin
                    ack_c   = 1'b1;
                    we_d    = 1'b1;
                    fp_d    = lu_fp;
                    addr_d  = lu_dest;
                    wdata_d = lu_data;
                end
            end
            HI: begin
                we_d    = 1'b1;
                fp_d    = 1'b1;
                addr_d  = hi_addr_q;
                wdata_d = hi_buf_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // The wait counter also clears when a request vanishes without an ack.
        if (ack_c) begin
            wait_d = '0;
        end else if (lu_req) begin
            wait_d = (wait_q == CNT_W'(STARVE_LIMIT)) ? wait_q : wait_q + CNT_W'(1);
        end else begin
            wait_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            hi_buf_q  <= '0;
            hi_addr_q <= '0;
            we_q      <= 1'b0;
            fp_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            hi_buf_q  <= hi_buf_d;
            hi_addr_q <= hi_addr_d;
            we_q      <= we_d;
            fp_q      <= fp_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign lu_ack   = ack_c && rst_n;
    assign stall_o  = stall_c && rst_n;
    assign rf_we    = we_q;
    assign rf_fp    = fp_q;
    assign rf_addr  = addr_q;
    assign rf_wdata = wdata_q;

endmodule

// File: tb/tb_wb_port_sequencer.sv
// Scenario bench for wb_port_sequencer: expected register writes are queued with
// their due cycle when granted and checked by a monitor as rf_we pulses appear.
module tb_wb_port_sequencer;

    logic        clk;
    logic        rst_n;
    logic        wb_regwrite;
    logic        wb_mem_read;
    logic [1:0]  wb_float;
    logic [4:0]  wb_dest;
    logic [31:0] wb_mem_data;
    logic [63:0] wb_alu_res;
    logic        lu_req;
    logic        lu_fp;
    logic [4:0]  lu_dest;
    logic [31:0] lu_data;
    logic        lu_ack;
    logic        stall_o;
    logic        rf_we;
    logic        rf_fp;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;

    typedef struct {
        int          cyc;
        logic        fp;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t sb[$];
    int  cyc = 0;
    int  compared = 0;
    int  mismatched = 0;

    wb_port_sequencer #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_regwrite(wb_regwrite), .wb_mem_read(wb_mem_read), .wb_float(wb_float),
        .wb_dest(wb_dest), .wb_mem_data(wb_mem_data), .wb_alu_res(wb_alu_res),
        .lu_req(lu_req), .lu_fp(lu_fp), .lu_dest(lu_dest), .lu_data(lu_data),
        .lu_ack(lu_ack), .stall_o(stall_o),
        .rf_we(rf_we), .rf_fp(rf_fp), .rf_addr(rf_addr), .rf_wdata(rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every rf_we pulse must match the oldest queued write, including its due cycle.
    always @(negedge clk) begin
        wr_t e;
        if (rf_we) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL unexpected_write: got fp=%0b addr=%0d data=%h at cyc %0d, none expected",
                         rf_fp, rf_addr, rf_wdata, cyc);
            end else begin
                e = sb.pop_front();
                if (rf_fp !== e.fp || rf_addr !== e.addr || rf_wdata !== e.data || cyc != e.cyc) begin
                    mismatched++;
                    $display("[TB] FAIL rf_write: got fp=%0b addr=%0d data=%h cyc=%0d, want fp=%0b addr=%0d data=%h cyc=%0d",
                             rf_fp, rf_addr, rf_wdata, cyc, e.fp, e.addr, e.data, e.cyc);
                end
            end
        end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            compared++;
            mismatched++;
            e = sb.pop_front();
            $display("[TB] FAIL missed_write: rf_we=0 at cyc %0d, want fp=%0b addr=%0d data=%h",
                     cyc, e.fp, e.addr, e.data);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pipe(input logic rw, input logic mr, input logic [1:0] fl,
                              input logic [4:0] dest, input logic [31:0] mem, input logic [63:0] alu);
        wb_regwrite = rw;
        wb_mem_read = mr;
        wb_float    = fl;
        wb_dest     = dest;
        wb_mem_data = mem;
        wb_alu_res  = alu;
    endtask

    task automatic drive_lu(input logic req, input logic fp, input logic [4:0] dest, input logic [31:0] data);
        lu_req  = req;
        lu_fp   = fp;
        lu_dest = dest;
        lu_data = data;
    endtask

    task automatic push_wr(input logic fp, input logic [4:0] addr, input logic [31:0] data, input int due);
        wr_t e;
        e.cyc  = due;
        e.fp   = fp;
        e.addr = addr;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic idle_and_drain(input string name);
        drive_pipe(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 64'h0);
        drive_lu(1'b0, 1'b0, 5'd0, 32'h0);
        repeat (3) next_cycle();
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL %s_drain: %0d writes still pending, want 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        drive_pipe(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 64'h0);
        drive_lu(1'b1, 1'b0, 5'd2, 32'h99);
        rst_n = 1'b0;
        repeat (2) next_cycle();
        compared++;
        if ({rf_we, rf_fp, rf_addr, rf_wdata} !== 39'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_rf: got we=%0b fp=%0b addr=%0d data=%h, want all 0",
                     rf_we, rf_fp, rf_addr, rf_wdata);
        end
        compared++;
        if (lu_ack !== 1'b0 || stall_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_ctl: got lu_ack=%0b stall_o=%0b, want 0 0", lu_ack, stall_o);
        end
        drive_lu(1'b0, 1'b0, 5'd0, 32'h0);
        rst_n = 1'b1;
        idle_and_drain("reset");
    endtask

    task automatic test_int_add();
        drive_pipe(1'b1, 1'b0, 2'b00, 5'd5, 32'hFFFF_FFFF, 64'h0000_0000_0000_1234);
        push_wr(1'b0, 5'd5, 32'h1234, cyc + 1);
        #2;
        compared++;
        if (stall_o !== 1'b0 || lu_ack !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL int_add_ctl: got stall_o=%0b lu_ack=%0b, want 0 0", stall_o, lu_ack);
        end
        next_cycle();
        idle_and_drain("int_add");
    endtask

    task automatic test_loads();
        // fp single load, then a double-typed load which is one write of memory data
        drive_pipe(1'b1, 1'b1, 2'b01, 5'd7, 32'hDEAD_BEEF, 64'h1111_2222_3333_4444);
        push_wr(1'b1, 5'd7, 32'hDEAD_BEEF, cyc + 1);
        next_cycle();
        drive_pipe(1'b1, 1'b1, 2'b10, 5'd12, 32'hCAFE_F00D, 64'h5555_6666_7777_8888);
        push_wr(1'b1, 5'd12, 32'hCAFE_F00D, cyc + 1);
        #2;
        compared++;
        if (stall_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL dbl_load_stall: got stall_o=%0b, want 0", stall_o);
        end
        next_cycle();
        drive_pipe(1'b1, 1'b0, 2'b11, 5'd9, 32'h0, 64'hFFFF_FFFF_0BAD_F00D);
        push_wr(1'b0, 5'd9, 32'h0BAD_F00D, cyc + 1);
        next_cycle();
        idle_and_drain("loads");
    endtask

    task automatic test_double(input logic [4:0] dest, input logic [63:0] res, input string name);
        drive_pipe(1'b1, 1'b0, 2'b10, dest, 32'h0, res);
        push_wr(1'b1, dest, res[31:0], cyc + 1);
        push_wr(1'b1, dest + 5'd1, res[63:32], cyc + 2);
        #2;
        compared++;
        if (stall_o !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL %s_stall_lo: got stall_o=%0b, want 1", name, stall_o);
        end
        next_cycle();
        #2;
        compared++;
        if (stall_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL %s_stall_hi: got stall_o=%0b, want 0", name, stall_o);
        end
        next_cycle();
        idle_and_drain(name);
    endtask

    task automatic test_idle_slot();
        drive_lu(1'b1, 1'b0, 5'd3, 32'h77);
        push_wr(1'b0, 5'd3, 32'h77, cyc + 1);
        #2;
        compared++;
        if (lu_ack !== 1'b1 || stall_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL idle_slot_ctl: got lu_ack=%0b stall_o=%0b, want 1 0", lu_ack, stall_o);
        end
        next_cycle();
        idle_and_drain("idle_slot");
    endtask

    task automatic test_r0_discard();
        drive_pipe(1'b1, 1'b0, 2'b00, 5'd0, 32'h0, 64'h0000_0000_0000_ABCD);
        drive_lu(1'b1, 1'b1, 5'd4, 32'h55);
        push_wr(1'b1, 5'd4, 32'h55, cyc + 1);
        #2;
        compared++;
        if (lu_ack !== 1'b1 || stall_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL r0_discard_ctl: got lu_ack=%0b stall_o=%0b, want 1 0", lu_ack, stall_o);
        end
        next_cycle();
        idle_and_drain("r0_discard");
    endtask

    task automatic test_contention();
        int e;
        logic want_ack;
        for (int c = 0; c < 7; c++) begin
            // The entry stalled by the starvation grant is presented again the next cycle.
            e = (c <= 4) ? c : c - 1;
            want_ack = (c == 4);
            drive_pipe(1'b1, 1'b0, 2'b00, 5'(e + 10), 32'h0, 64'(32'h100 + e));
            drive_lu(c <= 4, 1'b1, 5'd20, 32'hBEEF_0004);
            if (want_ack) push_wr(1'b1, 5'd20, 32'hBEEF_0004, cyc + 1);
            else          push_wr(1'b0, 5'(e + 10), 32'h100 + e, cyc + 1);
            #2;
            compared++;
            if (lu_ack !== want_ack || stall_o !== want_ack) begin
                mismatched++;
                $display("[TB] FAIL contention_c%0d: got lu_ack=%0b stall_o=%0b, want %0b %0b",
                         c, lu_ack, stall_o, want_ack, want_ack);
            end
            next_cycle();
        end
        idle_and_drain("contention");
    endtask

    task automatic test_reset_during_hi();
        drive_pipe(1'b1, 1'b0, 2'b10, 5'd10, 32'h0, 64'h1357_9BDF_2468_ACE0);
        push_wr(1'b1, 5'd10, 32'h2468_ACE0, cyc + 1);
        next_cycle();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        drive_pipe(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 64'h0);
        next_cycle();
        rst_n = 1'b1;
        #2;
        compared++;
        if (rf_we !== 1'b0 || stall_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rst_hi_out: got rf_we=%0b stall_o=%0b, want 0 0", rf_we, stall_o);
        end
        next_cycle();
        drive_pipe(1'b1, 1'b0, 2'b00, 5'd6, 32'h0, 64'h0000_0000_0000_0066);
        push_wr(1'b0, 5'd6, 32'h66, cyc + 1);
        #2;
        compared++;
        if (stall_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rst_hi_idle: got stall_o=%0b, want 0", stall_o);
        end
        next_cycle();
        idle_and_drain("rst_hi");
    endtask

    initial begin
        rst_n = 1'b0;
        drive_pipe(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 64'h0);
        drive_lu(1'b0, 1'b0, 5'd0, 32'h0);
        test_reset();
        test_int_add();
        test_loads();
        test_double(5'd8, 64'hAAAA_BBBB_CCCC_DDDD, "double");
        test_double(5'd31, 64'h0F0F_0F0F_F0F0_F0F0, "double_wrap");
        test_idle_slot();
        test_r0_discard();
        test_contention();
        test_reset_during_hi();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
